sdram_ctrl: RTL and testbench
=============================

SDRAM_CTRL -- requirements
Module: sdram_ctrl

Interface
REQ-001 Params: ADDR_WIDTH 13 (SDRAM address bus); DATA_WIDTH 16; BANK_WIDTH 2; COL_WIDTH 9; ROW_WIDTH 13; CAS_LATENCY 2; RD_CAPTURE 3 (cycles from READ on bus to dq capture); T_RCD 2; T_RP 2; T_RFC 7; INIT_CYCLES 100; REFRESH_INTERVAL 780.
REQ-002 Ports, clock and reset first: clk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-003 Host ports: req in 1, request valid; we in 1, 1=write; addr in BANK+ROW+COL, {bank,row,col}; wdata in DATA_WIDTH; be in DATA_WIDTH/8, byte enable, 1=write byte; ready out 1, accept when req&&ready; rdata out DATA_WIDTH; done out 1, one-cycle completion pulse; init_done out 1.
REQ-004 SDRAM ports: cke, cs_n, ras_n, cas_n, we_n out 1 each; a out ADDR_WIDTH; ba out BANK_WIDTH; dq inout DATA_WIDTH; dqm out DATA_WIDTH/8.

Function
REQ-005 All SDRAM outputs are registered; the command is one of NOP(0111), ACTIVE(0011), READ(0101), WRITE(0100), PRECHARGE(0010), AUTO REFRESH(0001), LOAD MODE(0000), encoded as {cs_n,ras_n,cas_n,we_n}; NOP in every cycle not listed below.
REQ-006 cke = 1 and cs_n = 0 in all cycles after reset release.
REQ-007 FSM states: INIT_WAIT, INIT_PRE, INIT_TRP, INIT_REF, INIT_TRFC, INIT_MRS, IDLE, ACT, TRCD, RW, CAS_WAIT, PRE, TRP, REF, TRFC.
REQ-008 Init sequence: INIT_CYCLES NOPs, then PRECHARGE with a[10]=1 and T_RP NOPs, then AUTO REFRESH twice (each followed by T_RFC NOPs), then LOAD MODE with a=0x020 (BL1, sequential, CL2), one NOP, then IDLE with init_done=1.
REQ-009 ready = 1 only in IDLE with init_done=1 and no pending refresh; a request is accepted only on a cycle where req && ready.
REQ-010 On acceptance, latch we, addr, wdata and be; issue ACTIVE with ba=bank and a=row on the next cycle; wait T_RCD-1 NOPs; then issue READ or WRITE with a={a[10]=0, col zero-extended} and ba=bank.
REQ-011 Write: dq is driven with wdata only during the WRITE cycle and dqm=~be; dq is high-Z in all other cycles.
REQ-012 Read: dqm=0; rdata captures dq at the end of cycle READ+RD_CAPTURE, and rdata holds its value until the next read capture.
REQ-013 After WRITE, or after the read capture: PRECHARGE with a[10]=0 and the same ba, then T_RP NOPs, then IDLE; done pulses for 1 cycle in the PRECHARGE cycle.
REQ-014 The refresh counter counts from reset release. Every REFRESH_INTERVAL cycles it sets refresh_pending; a pending that is already set stays set and does not accumulate.
REQ-015 In IDLE, refresh_pending takes priority over req: issue AUTO REFRESH, clear pending, insert T_RFC NOPs, then return to IDLE.
REQ-016 A refresh that falls due mid-transaction waits; the transaction is never aborted.
REQ-017 Requests are single-word and non-pipelined; a new request is not accepted until the FSM returns to IDLE.

Reset
REQ-018 rst_n low asynchronously forces: state INIT_WAIT; all counters 0; refresh_pending 0; command NOP; a=0; ba=0; dqm all-1; dq high-Z; rdata=0; ready=0; done=0; init_done=0; cke=0 while rst_n is low.
REQ-019 Reset asserted mid-transaction abandons the transaction with no done pulse; the full init sequence reruns after release.

Verification
REQ-020 Reset release with no requests -> INIT_CYCLES NOPs, PRECHARGE a[10]=1, 2 refreshes, LOAD MODE a=0x020; init_done rises at the expected cycle count.
REQ-021 Write addr={2,0x1A5,0x0F3}, wdata=0xBEEF, be=11 -> ACTIVE ba=2 row=0x1A5; WRITE col=0x0F3 after T_RCD; dq=0xBEEF; dqm=00; PRECHARGE ba=2; one done pulse.
REQ-022 Read back the same address from the SDRAM model -> rdata=0xBEEF at the READ+3 capture; done pulses once; ready returns after T_RP.
REQ-023 Write with be=01, wdata=0x1234 -> dqm=10 during WRITE; dq=0x1234.
REQ-024 Hold req high continuously until a refresh falls due -> the in-flight access completes; AUTO REFRESH precedes the next ACTIVE; ready=0 through T_RFC.
REQ-025 Pulse rst_n low during TRCD -> outputs take reset values immediately; no done pulse; init sequence repeats.

Source files
------------

// File: rtl/sdram_ctrl.sv
// Single-word SDR SDRAM controller: power-up init, periodic auto refresh and
// close-page read/write (every access is ACTIVE .. READ/WRITE .. PRECHARGE).
module sdram_ctrl #(
    parameter int ADDR_WIDTH       = 13,
    parameter int DATA_WIDTH       = 16,
    parameter int BANK_WIDTH       = 2,
    parameter int COL_WIDTH        = 9,
    parameter int ROW_WIDTH        = 13,
    parameter int CAS_LATENCY      = 2,
    parameter int RD_CAPTURE       = 3,
    parameter int T_RCD            = 2,
    parameter int T_RP             = 2,
    parameter int T_RFC            = 7,
    parameter int INIT_CYCLES      = 100,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req,
    input  logic                                     we,
    input  logic [BANK_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]                    wdata,
    input  logic [DATA_WIDTH/8-1:0]                  be,
    output logic                                     ready,
    output logic [DATA_WIDTH-1:0]                    rdata,
    output logic                                     done,
    output logic                                     init_done,
    output logic                                     cke,
    output logic                                     cs_n,
    output logic                                     ras_n,
    output logic                                     cas_n,
    output logic                                     we_n,
    output logic [ADDR_WIDTH-1:0]                    a,
    output logic [BANK_WIDTH-1:0]                    ba,
    inout  wire  [DATA_WIDTH-1:0]                    dq,
    output logic [DATA_WIDTH/8-1:0]                  dqm
);
    localparam int AW     = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int CNT_W  = 16;

    localparam logic [3:0] S_INIT_WAIT = 4'd0,  S_INIT_PRE = 4'd1,  S_INIT_TRP = 4'd2;
    localparam logic [3:0] S_INIT_REF  = 4'd3,  S_INIT_TRFC = 4'd4, S_INIT_MRS = 4'd5;
    localparam logic [3:0] S_IDLE      = 4'd6,  S_ACT = 4'd7,       S_TRCD = 4'd8;
    localparam logic [3:0] S_RW        = 4'd9,  S_CAS_WAIT = 4'd10, S_PRE = 4'd11;
    localparam logic [3:0] S_TRP       = 4'd12, S_REF = 4'd13,      S_TRFC = 4'd14;

    localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam logic [CNT_W-1:0] INIT_N = CNT_W'(INIT_CYCLES);
    localparam logic [CNT_W-1:0] RP_N   = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] RFC_N  = CNT_W'(T_RFC);
    localparam logic [CNT_W-1:0] RCD_N  = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] CAP_N  = CNT_W'(RD_CAPTURE);
    localparam logic [CNT_W-1:0] REF_N  = CNT_W'(REFRESH_INTERVAL - 1);
    // Mode word: burst length 1, sequential, CAS latency in a[6:4].
    localparam logic [ADDR_WIDTH-1:0] MODE_WORD = ADDR_WIDTH'(CAS_LATENCY * 16);
    localparam logic [ADDR_WIDTH-1:0] A10_ALL   = ADDR_WIDTH'(1024);

    logic [3:0]             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       ref_cnt_reg;
    logic                   refresh_pending_reg;
    logic                   init_ref_reg;
    logic                   init_done_reg;
    logic                   we_reg;
    logic [COL_WIDTH-1:0]   col_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;
    logic [BYTES-1:0]       be_reg;
    logic [3:0]             cmd_reg;
    logic [ADDR_WIDTH-1:0]  a_reg;
    logic [BANK_WIDTH-1:0]  ba_reg;
    logic [BYTES-1:0]       dqm_reg;
    logic [DATA_WIDTH-1:0]  dq_out_reg;
    logic                   dq_oe_reg;
    logic [DATA_WIDTH-1:0]  rdata_reg;
    logic                   done_reg;
    logic                   cke_reg;

    logic [BANK_WIDTH-1:0]  bank_in;
    logic [ROW_WIDTH-1:0]   row_in;
    logic [BYTES-1:0]       wr_mask;

    assign bank_in = addr[AW-1 -: BANK_WIDTH];
    assign row_in  = addr[COL_WIDTH +: ROW_WIDTH];

    // dqm is a mask: a set bit blocks that byte lane.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_wr_mask
        assign wr_mask[gi] = ~be_reg[gi];
    end

    assign ready     = (state_reg == S_IDLE) && init_done_reg && !refresh_pending_reg;
    assign rdata     = rdata_reg;
    assign done      = done_reg;
    assign init_done = init_done_reg;
    assign cke       = cke_reg;
    assign {cs_n, ras_n, cas_n, we_n} = cmd_reg;
    assign a         = a_reg;
    assign ba        = ba_reg;
    assign dqm       = dqm_reg;
    assign dq        = dq_oe_reg ? dq_out_reg : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= S_INIT_WAIT;
            cnt_reg             <= '0;
            ref_cnt_reg         <= '0;
            refresh_pending_reg <= 1'b0;
            init_ref_reg        <= 1'b0;
            init_done_reg       <= 1'b0;
            we_reg              <= 1'b0;
            col_reg             <= '0;
            wdata_reg           <= '0;
            be_reg              <= '0;
            cmd_reg             <= CMD_NOP;
            a_reg               <= '0;
            ba_reg              <= '0;
            dqm_reg             <= '1;
            dq_out_reg          <= '0;
            dq_oe_reg           <= 1'b0;
            rdata_reg           <= '0;
            done_reg            <= 1'b0;
            cke_reg             <= 1'b0;
        end else begin
            cmd_reg   <= CMD_NOP;
            done_reg  <= 1'b0;
            dq_oe_reg <= 1'b0;
            cke_reg   <= 1'b1;
            case (state_reg)
                S_INIT_WAIT: begin
                    if (cnt_reg == INIT_N) begin
                        state_reg <= S_INIT_PRE;
                        cmd_reg   <= CMD_PRE;
                        a_reg     <= A10_ALL;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_INIT_PRE: begin
                    state_reg <= S_INIT_TRP;
                    cnt_reg   <= CNT_W'(1);
                end
                S_INIT_TRP: begin
                    if (cnt_reg == RP_N) begin
                        state_reg <= S_INIT_REF;
                        cmd_reg   <= CMD_REF;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_INIT_REF: begin
                    state_reg <= S_INIT_TRFC;
                    cnt_reg   <= CNT_W'(1);
                end
                S_INIT_TRFC: begin
                    if (cnt_reg != RFC_N) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (init_ref_reg) begin
                        state_reg <= S_INIT_MRS;
                        cmd_reg   <= CMD_MRS;
                        a_reg     <= MODE_WORD;
                        cnt_reg   <= '0;
                    end else begin
                        init_ref_reg <= 1'b1;
                        state_reg    <= S_INIT_REF;
                        cmd_reg      <= CMD_REF;
                    end
                end
                // First cycle issues LOAD MODE, second is the trailing NOP.
                S_INIT_MRS: begin
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg     <= S_IDLE;
                        init_done_reg <= 1'b1;
                    end else begin
                        cnt_reg <= CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (refresh_pending_reg) begin
                        state_reg           <= S_REF;
                        cmd_reg             <= CMD_REF;
                        refresh_pending_reg <= 1'b0;
                    end else if (req && ready) begin
                        we_reg    <= we;
                        col_reg   <= addr[COL_WIDTH-1:0];
                        wdata_reg <= wdata;
                        be_reg    <= be;
                        state_reg <= S_ACT;
                        cmd_reg   <= CMD_ACT;
                        a_reg     <= ADDR_WIDTH'(row_in);
                        ba_reg    <= bank_in;
                    end
                end
                S_ACT: begin
                    state_reg <= S_TRCD;
                    cnt_reg   <= CNT_W'(1);
                end
                S_TRCD: begin
                    if (cnt_reg == RCD_N) begin
                        state_reg <= S_RW;
                        cmd_reg   <= we_reg ? CMD_WR : CMD_RD;
                        a_reg     <= ADDR_WIDTH'(col_reg);
                        if (we_reg) begin
                            dq_out_reg <= wdata_reg;
                            dq_oe_reg  <= 1'b1;
                            dqm_reg    <= wr_mask;
                        end else begin
                            dqm_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RW: begin
                    if (we_reg) begin
                        state_reg <= S_PRE;
                        cmd_reg   <= CMD_PRE;
                        a_reg     <= '0;
                        dqm_reg   <= '1;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= S_CAS_WAIT;
                        cnt_reg   <= CNT_W'(1);
                    end
                end
                // Read data is sampled on the same edge that issues PRECHARGE.
                S_CAS_WAIT: begin
                    if (cnt_reg == CAP_N) begin
                        rdata_reg <= dq;
                        state_reg <= S_PRE;
                        cmd_reg   <= CMD_PRE;
                        a_reg     <= '0;
                        dqm_reg   <= '1;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_PRE: begin
                    state_reg <= S_TRP;
                    cnt_reg   <= CNT_W'(1);
                end
                S_TRP: begin
                    if (cnt_reg == RP_N) state_reg <= S_IDLE;
                    else                 cnt_reg   <= cnt_reg + 1'b1;
                end
                S_REF: begin
                    state_reg <= S_TRFC;
                    cnt_reg   <= CNT_W'(1);
                end
                S_TRFC: begin
                    if (cnt_reg == RFC_N) state_reg <= S_IDLE;
                    else                  cnt_reg   <= cnt_reg + 1'b1;
                end
                default: state_reg <= S_INIT_WAIT;
            endcase
            // Placed after the FSM so a tick coinciding with the IDLE clear wins.
            if (ref_cnt_reg == REF_N) begin
                ref_cnt_reg         <= '0;
                refresh_pending_reg <= 1'b1;
            end else begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a behavioural single-word SDRAM model on dq.
module tb_sdram_ctrl;
    localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [23:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;
    logic        ready, done, init_done, cke, cs_n, ras_n, cas_n, we_n;
    logic [15:0] rdata;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    wire  [15:0] dq;
    wire  [3:0]  cmd = {cs_n, ras_n, cas_n, we_n};

    logic        mdl_oe = 1'b0;
    logic [15:0] mdl_data = '0;
    assign dq = mdl_oe ? mdl_data : 16'hzzzz;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [15:0] last_rdata = '0;

    typedef struct {
        logic        we;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [1:0]  exp_dqm;
        logic [15:0] exp_rdata;
    } txn_t;
    txn_t vec [10];

    sdram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .rdata(rdata), .done(done), .init_done(init_done),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .a(a), .ba(ba), .dq(dq), .dqm(dqm)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    // SDRAM model: remembers the open row per bank, honours dqm on writes,
    // and drives read data from READ+2 until just after READ+3.
    logic [15:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    logic [23:0] mkey;
    logic [15:0] mtmp;
    int          rd_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0;
            mdl_oe = 1'b0;
        end else begin
            if (rd_cnt != 0) rd_cnt = rd_cnt + 1;
            mkey = {ba, open_row[ba], a[8:0]};
            case (cmd)
                CMD_ACT: open_row[ba] = a;
                CMD_WR: begin
                    mtmp = mem.exists(mkey) ? mem[mkey] : 16'h0000;
                    for (int b = 0; b < 2; b++)
                        if (!dqm[b]) mtmp[b*8 +: 8] = dq[b*8 +: 8];
                    mem[mkey] = mtmp;
                end
                CMD_RD: begin
                    rd_cnt   = 1;
                    mdl_data = mem.exists(mkey) ? mem[mkey] : 16'h0000;
                end
                default: ;
            endcase
            if (rd_cnt > 4) rd_cnt = 0;
            mdl_oe = (rd_cnt == 3) || (rd_cnt == 4);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_init();
        logic [3:0] exp_cmd;
        int c;
        while (cyc < 125) begin
            @(negedge clk);
            c = cyc;
            case (c)
                101:      exp_cmd = CMD_PRE;
                104, 112: exp_cmd = CMD_REF;
                120:      exp_cmd = CMD_MRS;
                default:  exp_cmd = CMD_NOP;
            endcase
            chk($sformatf("init_cmd_c%0d", c), cmd, exp_cmd);
            chk("init_cke", cke, 1);
            chk("init_done", init_done, c >= 122);
            chk("init_ready", ready, c >= 122);
            if (c == 101) chk("init_pre_a10", a[10], 1);
            if (c == 120) chk("init_mrs_a", a, 13'h020);
        end
    endtask

    task automatic run_txn(input txn_t t, input int idx);
        int budget;
        @(negedge clk);
        req = 1'b1; we = t.we; addr = {t.bank, t.row, t.col}; wdata = t.wdata; be = t.be;
        budget = 0;
        while (!ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_wait", ready, 1);
        @(negedge clk);
        req = 1'b0;
        chk("act_cmd", cmd, CMD_ACT);
        chk("act_ba", ba, t.bank);
        chk("act_row", a, t.row);
        chk("act_done", done, 0);
        @(negedge clk);
        chk("trcd_cmd", cmd, CMD_NOP);
        @(negedge clk);
        chk("rw_cmd", cmd, t.we ? CMD_WR : CMD_RD);
        chk("rw_col", a, {4'b0, t.col});
        chk("rw_ba", ba, t.bank);
        chk("rw_dqm", dqm, t.exp_dqm);
        if (t.we) begin
            chk("wr_dq", dq, t.wdata);
        end else begin
            repeat (3) @(negedge clk);
            chk("cas_cmd", cmd, CMD_NOP);
            chk("rdata_hold", rdata, last_rdata);
            chk("cas_done", done, 0);
        end
        @(negedge clk);
        chk("pre_cmd", cmd, CMD_PRE);
        chk("pre_a10", a[10], 0);
        chk("pre_ba", ba, t.bank);
        chk("pre_done", done, 1);
        if (!t.we) begin
            chk("rdata", rdata, t.exp_rdata);
            last_rdata = t.exp_rdata;
        end
        repeat (2) begin
            @(negedge clk);
            chk("trp_cmd", cmd, CMD_NOP);
            chk("trp_ready", ready, 0);
            chk("trp_done", done, 0);
        end
        @(negedge clk);
        chk("idle_ready", ready, 1);
        $display("txn %0d: %s ba=%0d row=%h col=%h wdata=%h be=%b rdata=%h", idx,
                 t.we ? "WR" : "RD", t.bank, t.row, t.col, t.wdata, t.be, rdata);
    endtask

    initial begin
        logic [3:0] exp_cmd;
        int c, d0, budget;

        vec[0] = '{1'b1, 2'd2, 13'h1A5,  9'h0F3, 16'hBEEF, 2'b11, 2'b00, 16'h0000};
        vec[1] = '{1'b0, 2'd2, 13'h1A5,  9'h0F3, 16'h0000, 2'b00, 2'b00, 16'hBEEF};
        vec[2] = '{1'b1, 2'd1, 13'h0010, 9'h001, 16'hAAAA, 2'b11, 2'b00, 16'h0000};
        vec[3] = '{1'b1, 2'd1, 13'h0010, 9'h001, 16'h1234, 2'b01, 2'b10, 16'h0000};
        vec[4] = '{1'b0, 2'd1, 13'h0010, 9'h001, 16'h0000, 2'b00, 2'b00, 16'hAA34};
        vec[5] = '{1'b1, 2'd3, 13'h1FFF, 9'h1FF, 16'h5A5A, 2'b10, 2'b01, 16'h0000};
        vec[6] = '{1'b0, 2'd3, 13'h1FFF, 9'h1FF, 16'h0000, 2'b00, 2'b00, 16'h5A00};
        vec[7] = '{1'b0, 2'd2, 13'h1A5,  9'h0F3, 16'h0000, 2'b00, 2'b00, 16'hBEEF};
        vec[8] = '{1'b1, 2'd0, 13'h0000, 9'h000, 16'hFFFF, 2'b11, 2'b00, 16'h0000};
        vec[9] = '{1'b0, 2'd0, 13'h0000, 9'h000, 16'h0000, 2'b00, 2'b00, 16'hFFFF};

        // Reset values while rst_n is held low.
        repeat (3) @(negedge clk);
        chk("rst_cke", cke, 0);
        chk("rst_cmd", cmd, CMD_NOP);
        chk("rst_a", a, 0);
        chk("rst_ba", ba, 0);
        chk("rst_dqm", dqm, 2'b11);
        chk("rst_rdata", rdata, 0);
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_init_done", init_done, 0);
        #1 rst_n = 1'b1;
        check_init();

        for (int i = 0; i < 10; i++) run_txn(vec[i], i);

        // Continuous requests across the refresh tick at cycle 780.
        while (cyc < 775) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = {2'd2, 13'h1A5, 9'h0F3};
        while (cyc < 805) begin
            @(negedge clk);
            c = cyc;
            case (c)
                776, 795: exp_cmd = CMD_ACT;
                778, 797: exp_cmd = CMD_RD;
                782, 801: exp_cmd = CMD_PRE;
                786:      exp_cmd = CMD_REF;
                default:  exp_cmd = CMD_NOP;
            endcase
            chk($sformatf("refq_cmd_c%0d", c), cmd, exp_cmd);
            chk("refq_done", done, (c == 782) || (c == 801));
            chk("refq_ready", ready, (c == 794) || (c >= 804));
            if (c == 781) chk("refq_rdata_hold", rdata, 16'hFFFF);
            if (c == 782) chk("refq_rdata", rdata, 16'hBEEF);
            if (c == 795) req = 1'b0;
        end
        $display("txn refresh: read in flight completed, AUTO REFRESH before next ACTIVE");

        // Reset asserted while the controller sits in TRCD.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = {2'd1, 13'h0ABC, 9'h055}; wdata = 16'hDEAD; be = 2'b11;
        budget = 0;
        while (!ready && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        req = 1'b0;
        chk("mr_act", cmd, CMD_ACT);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_cke", cke, 0);
        chk("mr_cmd", cmd, CMD_NOP);
        chk("mr_a", a, 0);
        chk("mr_ba", ba, 0);
        chk("mr_dqm", dqm, 2'b11);
        chk("mr_done", done, 0);
        chk("mr_ready", ready, 0);
        chk("mr_init_done", init_done, 0);
        chk("mr_rdata", rdata, 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        chk("mr_hold_cmd", cmd, CMD_NOP);
        chk("mr_hold_cke", cke, 0);
        #1 rst_n = 1'b1;
        check_init();
        #1;
        chk("mr_no_done", done_cnt, d0);
        $display("txn reset: write abandoned in TRCD, init sequence repeated");
        last_rdata = 16'h0000;
        run_txn(vec[7], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
